// File: rtl/nibble_serial_add_seq.sv
// Multi-cycle WIDTH-bit adder that time-multiplexes an external 4-bit ripple adder, one nibble per cycle.
// Optional macro NIBBLE_SEQ_SUB_EN adds a 'sub' input that turns the operation into op_a - op_b.
module nibble_serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef NIBBLE_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [4:0]       add_sum
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             last_nibble;

  // Subtraction is a + ~b + 1, so only the captured B and carry differ.
`ifdef NIBBLE_SEQ_SUB_EN
  assign b_in = sub ? ~op_b : op_b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = op_b;
  assign c_in = cin;
`endif

  assign last_nibble = (k == K_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_nibble) begin
          state_next = DONE;
        end else begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags and adder drive, decoded from the registered state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 4'h0;
    add_b     = 4'h0;
    add_cin   = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        add_a   = a_reg[{k, 2'b00} +: 4];
        add_b   = b_reg[{k, 2'b00} +: 4];
        add_cin = carry_reg;
      end
      DONE:    out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Operand capture, per-nibble result assembly and carry chaining
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= b_in;
            carry_reg <= c_in;
            k         <= '0;
          end
        end
        RUN: begin
          result[{k, 2'b00} +: 4] <= add_sum[3:0];
          carry_reg               <= add_sum[4];
          if (last_nibble) begin
            k    <= '0;
            cout <= add_sum[4];
            // add_sum[3] becomes result[WIDTH-1] on this same edge
            ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (add_sum[3] != a_reg[WIDTH-1]);
          end else begin
            k <= k + K_ONE;
          end
        end
        default: k <= k;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Self-checking bench for nibble_serial_add_seq: transaction-level arithmetic model plus directed literal checks.
module tb_nibble_serial_add_seq;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
`ifdef NIBBLE_SEQ_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [4:0]   add_sum;

  int n_checks = 0;
  int n_errors = 0;

  nibble_serial_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef NIBBLE_SEQ_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .ovf(ovf), .add_a(add_a), .add_b(add_b),
    .add_cin(add_cin), .add_sum(add_sum)
  );

  // The team's 4-bit ripple adder, modelled arithmetically
  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_cin};

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint to_s(input longint v);
    return v[W-1] ? v - (longint'(1) << W) : v;
  endfunction

  // Behavioural model state
  bit     m_busy = 1'b0;
  bit     m_done = 1'b0;
  int     m_left = 0;
  longint m_a, m_b, m_c;
  longint e_res = 0, e_cout = 0, e_ovf = 0;

  // Compare outputs on every falling edge, then advance the model by the inputs the next rising edge sees
  always @(negedge clk) begin
    longint mask_w, msk, full, sv;
    bit     s;
    int     j;
    mask_w = (longint'(1) << W) - 1;
    if (rst) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_add", {add_a, add_b, add_cin}, 0);
      m_busy = 1'b0; m_done = 1'b0; e_res = 0; e_cout = 0; e_ovf = 0;
    end else begin
      chk("in_ready", in_ready, (!m_busy && !m_done));
      chk("out_valid", out_valid, m_done);
      if (m_done) begin
        chk("result", result, e_res);
        chk("cout", cout, e_cout);
        chk("ovf", ovf, e_ovf);
      end else if (m_busy) begin
        j   = N - m_left;
        msk = (longint'(1) << (4 * j)) - 1;
        chk("add_a", add_a, (m_a >> (4 * j)) & 15);
        chk("add_b", add_b, (m_b >> (4 * j)) & 15);
        chk("add_cin", add_cin, (((m_a & msk) + (m_b & msk) + m_c) >> (4 * j)) & 1);
      end else begin
        chk("idle_result", result, e_res);
        chk("idle_cout", cout, e_cout);
        chk("idle_add", {add_a, add_b, add_cin}, 0);
      end

      if (!m_busy && !m_done) begin
        if (in_valid) begin
`ifdef NIBBLE_SEQ_SUB_EN
          s = sub;
`else
          s = 1'b0;
`endif
          m_a = longint'(op_a);
          if (s) begin
            m_b    = (~longint'(op_b)) & mask_w;
            m_c    = 1;
            e_res  = (longint'(op_a) - longint'(op_b)) & mask_w;
            e_cout = (longint'(op_a) >= longint'(op_b)) ? 1 : 0;
            sv     = to_s(longint'(op_a)) - to_s(longint'(op_b));
          end else begin
            m_b    = longint'(op_b);
            m_c    = longint'(cin);
            full   = longint'(op_a) + longint'(op_b) + longint'(cin);
            e_res  = full & mask_w;
            e_cout = (full >> W) & 1;
            sv     = to_s(longint'(op_a)) + to_s(longint'(op_b)) + longint'(cin);
          end
          e_ovf  = (sv > ((longint'(1) << (W - 1)) - 1) || sv < -(longint'(1) << (W - 1))) ? 1 : 0;
          m_busy = 1'b1;
          m_left = N;
        end
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (out_ready) begin
        m_done = 1'b0;
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    @(posedge clk); #1;
    in_valid = 1'b1; op_a = a; op_b = b; cin = c;
`ifdef NIBBLE_SEQ_SUB_EN
    sub = s;
`else
    if (s) $display("note: sub requested without subtract support");
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit noise, output int lat, output logic [7:0] cs);
    lat = 0;
    cs  = '0;
    while (!out_valid && lat < 64) begin
      if (lat < 8) cs[lat] = add_cin;
      if (noise) begin
        out_ready = 1'($urandom);
        in_valid  = 1'($urandom);
        op_a      = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!out_valid) chk("done_timeout", 0, 1);
  endtask

  task automatic release_op();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int         lat;
    logic [7:0] cs;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(1'b0, lat, cs);
    chk("lat_1234", lat, 4);
    chk("res_1234", result, 16'h5555);
    chk("cout_1234", cout, 0);
    chk("ovf_1234", ovf, 0);
    release_op();

    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(1'b0, lat, cs);
    chk("res_ffff", result, 16'h0000);
    chk("cout_ffff", cout, 1);
    chk("cinseq_ffff", cs[3:0], 4'b1110);
    release_op();

    start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(1'b0, lat, cs);
    chk("res_7fff", result, 16'h8000);
    chk("cout_7fff", cout, 0);
    chk("ovf_7fff", ovf, 1);
    release_op();

    // Backpressure with new operands held on the input
    start_op(16'h00F0, 16'h0F0F, 1'b1, 1'b0);
    wait_done(1'b0, lat, cs);
    in_valid = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; cin = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
      chk("bp_result", result, 16'h1000);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", in_ready, 0);
    wait_done(1'b0, lat, cs);
    chk("bp_res2", result, 16'hFFFF);
    chk("bp_cout2", cout, 0);
    release_op();

    // Reset during the third RUN cycle
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_add", {add_a, add_b, add_cin}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      chk("post_rst_valid", out_valid, 0);
    end

`ifdef NIBBLE_SEQ_SUB_EN
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done(1'b0, lat, cs);
    chk("sub_res_5m7", result, 16'hFFFE);
    chk("sub_cout_5m7", cout, 0);
    chk("sub_ovf_5m7", ovf, 0);
    release_op();
    start_op(16'h8000, 16'h0001, 1'b1, 1'b1);
    wait_done(1'b0, lat, cs);
    chk("sub_res_8000", result, 16'h7FFF);
    chk("sub_cout_8000", cout, 1);
    chk("sub_ovf_8000", ovf, 1);
    release_op();
`endif

    for (int i = 0; i < 40; i++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      wait_done(1'b1, lat, cs);
      chk("rand_lat", lat, N);
      repeat ($urandom_range(2, 0)) begin
        in_valid = 1'($urandom);
        @(posedge clk); #1;
      end
      release_op();
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_seq.md
Name: nibble_serial_add_seq

Overview:
- Sequencer that performs WIDTH-bit addition by time-multiplexing the team's 4-bit ripple adder (5-bit sum output, carry in bit 4).
- Sits directly around that adder:
  - upstream: feeds it one nibble pair plus carry-in per cycle;
  - downstream: consumes its 5-bit result, assembling the wide sum and chaining the carry through a register.
- Used by the CPU datapath for 16/32-bit adds without widening the combinational adder.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4, minimum 4.
- NIBBLES, WIDTH/4, derived localparam; number of adder passes.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- cin  input  1  carry into bit 0
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  sum
- cout  output  1  carry out of MSB
- ovf  output  1  signed overflow
- add_a  output  4  nibble of A to adder
- add_b  output  4  nibble of B to adder
- add_cin  output  1  carry to adder
- add_sum  input  5  adder result, bit 4 = nibble carry

Behaviour:
- Clock/reset:
  - Single clock clk.
  - Reset rst is asynchronous, active-high.
  - On rst assertion, immediately, independent of clk:
    - state=IDLE, nibble index k=0, carry_reg=0;
    - operand regs=0, result=0, cout=0, ovf=0;
    - out_valid=0, in_ready=1 once state is IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture op_a, op_b, cin into a_reg, b_reg, carry_reg; k<=0; go RUN.
- RUN, NIBBLES cycles:
  - Adder drive (combinational from registers): add_a=a_reg[4k+3:4k], add_b=b_reg[4k+3:4k], add_cin=carry_reg.
  - Each edge: result[4k+3:4k]<=add_sum[3:0], carry_reg<=add_sum[4], k<=k+1.
  - After the edge where k==NIBBLES-1: cout<=add_sum[4]; go DONE.
- DONE:
  - out_valid=1.
  - result, cout, ovf held stable until out_ready sampled high, then go IDLE.
- Overflow: ovf = (a_reg[WIDTH-1]==b_reg[WIDTH-1]) && (result[WIDTH-1]!=a_reg[WIDTH-1]); valid in DONE only.
- Latency:
  - Acceptance edge E0; out_valid rises after edge E0+NIBBLES; 4 cycles for WIDTH=16.
  - Throughput: one operation per NIBBLES+2 cycles minimum.
- in_ready=1 only in IDLE. in_valid in RUN/DONE is ignored; operands are not captured.
- add_a, add_b, add_cin = 0 outside RUN.
- result/cout keep the last completed values in IDLE; out_valid=0 there.
- Wrap-around: result is modulo 2^WIDTH; carry beyond MSB appears only on cout.
- Reset mid-RUN or mid-DONE: operation abandoned, no out_valid pulse, all outputs to reset values.
- out_ready while not DONE: no effect.

Optional Feature:
- Macro: NIBBLE_SEQ_SUB_EN.
- Defined:
  - Extra input port sub, 1 bit, sampled with the operands at acceptance.
  - If sub=1: b_reg<=~op_b, carry_reg<=1, cin ignored; result=op_a-op_b.
  - cout=1 means no borrow.
  - ovf uses the inverted b_reg, i.e. correct for signed subtraction.
- Undefined: no sub port; addition only.

Test Plan:
- WIDTH=16, op_a=0x1234, op_b=0x4321, cin=0 -> result=0x5555, cout=0, ovf=0; out_valid high exactly 4 cycles after the accept edge.
- op_a=0xFFFF, op_b=0x0001, cin=0 -> result=0x0000, cout=1; add_cin observed as 0,1,1,1 on the four RUN cycles.
- op_a=0x7FFF, op_b=0x0001, cin=0 -> result=0x8000, cout=0, ovf=1.
- Backpressure: out_ready low for 3 cycles in DONE with in_valid held high -> result/out_valid stable, in_ready=0, no capture; out_ready=1 -> IDLE next cycle, new operands accepted the cycle after.
- Assert rst for 1 cycle during the 3rd RUN cycle of 0xFFFF+0x0001 -> immediately state IDLE, out_valid=0, result=0, add_*=0; no out_valid pulse afterwards.
- With NIBBLE_SEQ_SUB_EN: sub=1, op_a=0x0005, op_b=0x0007 -> result=0xFFFE, cout=0, ovf=0; sub=1, 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
